// File: rtl/ascii_hex_parser_pkg.sv
// Shared types and character classification for the ASCII hex field parser.
// Define ASCII_HEX_LOWERCASE_EN to also accept 'a'-'f' as hex digits.
package ascii_hex_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT,
    ST_DISCARD
  } t_parse_state;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  function automatic logic is_hex_digit(input logic [7:0] c);
    logic r;
    r = ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
`ifdef ASCII_HEX_LOWERCASE_EN
    r = r || ((c >= 8'h61) && (c <= 8'h66));
`endif
    return r;
  endfunction

  function automatic logic is_terminator(input logic [7:0] c);
    return (c == CH_LF) || (c == CH_CR) || (c == CH_SPACE) || (c == CH_COMMA);
  endfunction

  // Only meaningful when is_hex_digit(c) holds.
  function automatic logic [3:0] nibble_of_ascii(input logic [7:0] c);
    if (c <= 8'h39) return 4'(c - 8'h30);
`ifdef ASCII_HEX_LOWERCASE_EN
    if (c >= 8'h61) return 4'(c - 8'h57);
`endif
    return 4'(c - 8'h37);
  endfunction

endpackage

// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex field decoder: characters in under valid/ready, held value out.
// Lowercase digit support is enabled by defining ASCII_HEX_LOWERCASE_EN.
module ascii_hex_parser
  import ascii_hex_parser_pkg::*;
#(
  parameter int DIGITS_MAX = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_char_valid,
  input  logic [7:0]              i_char,
  output logic                    o_char_ready,
  output logic                    o_value_valid,
  output logic [4*DIGITS_MAX-1:0] o_value,
  output logic [3:0]              o_value_digits,
  input  logic                    i_value_ready,
  output logic                    o_error,
  output logic                    o_overflow
);

  localparam int VAL_W = 4 * DIGITS_MAX;

  t_parse_state     state_q, state_d;
  logic [VAL_W-1:0] acc_q, acc_d, value_q, value_d;
  logic [3:0]       count_q, count_d, digits_q, digits_d;
  logic             ready_q;
  logic             err_q, err_d, ovf_q, ovf_d;
  logic             accept, ch_digit, ch_term;
  logic [3:0]       nib;

  assign accept   = i_char_valid && ready_q;
  assign ch_digit = is_hex_digit(i_char);
  assign ch_term  = is_terminator(i_char);
  assign nib      = nibble_of_ascii(i_char);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    value_d  = value_q;
    digits_d = digits_q;
    err_d    = 1'b0;
    ovf_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ch_digit) begin
            acc_d   = VAL_W'(nib);
            count_d = 4'd1;
            state_d = ST_ACCUM;
          end else if (!ch_term) begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (ch_digit) begin
            if (count_q == 4'(DIGITS_MAX)) begin
              err_d   = 1'b1;
              ovf_d   = 1'b1;
              state_d = ST_DISCARD;
            end else begin
              acc_d   = (acc_q << 4) | VAL_W'(nib);
              count_d = count_q + 4'd1;
            end
          end else if (ch_term) begin
            value_d  = acc_q;
            digits_d = count_q;
            state_d  = ST_EMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_EMIT: begin
        if (i_value_ready) state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (accept && ch_term) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it drops the cycle after a
  // terminator and returns the cycle after the value handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      value_q  <= '0;
      digits_q <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      value_q  <= value_d;
      digits_q <= digits_d;
      ready_q  <= (state_d != ST_EMIT);
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_char_ready   = ready_q;
  assign o_value_valid  = (state_q == ST_EMIT);
  assign o_value        = value_q;
  assign o_value_digits = digits_q;
  assign o_error        = err_q;
  assign o_overflow     = ovf_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Scoreboard bench for ascii_hex_parser: token-level reference model feeds expected
// values/errors into queues, a negedge monitor pops and compares DUT outputs.
module tb_ascii_hex_parser;

  localparam int DM = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_char_valid;
  logic [7:0]    i_char;
  logic          o_char_ready;
  logic          o_value_valid;
  logic [4*DM-1:0] o_value;
  logic [3:0]    o_value_digits;
  logic          i_value_ready;
  logic          o_error;
  logic          o_overflow;

  ascii_hex_parser #(.DIGITS_MAX(DM)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_char_valid   (i_char_valid),
    .i_char         (i_char),
    .o_char_ready   (o_char_ready),
    .o_value_valid  (o_value_valid),
    .o_value        (o_value),
    .o_value_digits (o_value_digits),
    .i_value_ready  (i_value_ready),
    .o_error        (o_error),
    .o_overflow     (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     rdy_mode = 0;  // 0 random, 1 always ready, 2 never ready
  longint exp_val[$];
  int     exp_dig[$];
  bit     exp_ovf[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int hexval(input byte c);
    string up = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++) if (c == up[i]) return i;
`ifdef ASCII_HEX_LOWERCASE_EN
    begin
      string lo = "0123456789abcdef";
      for (int i = 10; i < 16; i++) if (c == lo[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic bit is_term(input byte c);
    return c inside {8'h0A, 8'h0D, 8'h20, 8'h2C};
  endfunction

  task automatic model_tok(input byte t[$]);
    longint v = 0;
    if (t.size() == 0) return;
    for (int i = 0; i < t.size(); i++) begin
      int d = hexval(t[i]);
      if (d < 0) begin exp_ovf.push_back(1'b0); return; end
      if (i == DM) begin exp_ovf.push_back(1'b1); return; end
      v = v * 16 + d;
    end
    exp_val.push_back(v);
    exp_dig.push_back(t.size());
  endtask

  task automatic model_seq(input byte q[$]);
    byte tok[$];
    for (int i = 0; i < q.size(); i++) begin
      if (is_term(q[i])) begin
        model_tok(tok);
        tok.delete();
      end else tok.push_back(q[i]);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic send_char(input byte c, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
    i_char_valid = 1'b1;
    i_char       = c;
    forever begin
      @(negedge i_clk);
      if (o_char_ready) begin @(posedge i_clk); #1; cyc++; break; end
      @(posedge i_clk); #1; cyc++;
      if (++n > 200) begin check("char_accept_timeout", 0, 1); break; end
    end
    i_char_valid = 1'b0;
    i_char       = 8'($urandom);
  endtask

  task automatic send_seq(input byte q[$], input bit gaps, input bit use_model);
    if (use_model) model_seq(q);
    for (int i = 0; i < q.size(); i++) send_char(q[i], gaps);
  endtask

  task automatic send_str(input string s, input bit gaps, input bit use_model);
    byte q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_seq(q, gaps, use_model);
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_char_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("wait_ready_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_char_ready"}, o_char_ready, 0);
    check({tag, "_value_valid"}, o_value_valid, 0);
    check({tag, "_value"}, o_value, 0);
    check({tag, "_digits"}, o_value_digits, 0);
    check({tag, "_error"}, o_error, 0);
    check({tag, "_overflow"}, o_overflow, 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", o_char_ready, 0);
    @(posedge i_clk); #1;
    check("ready_after_first_edge", o_char_ready, 1);
  endtask

  // ---------------- consumer ----------------
  initial begin
    i_value_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      case (rdy_mode)
        1:       i_value_ready = 1'b1;
        2:       i_value_ready = 1'b0;
        default: i_value_ready = 1'($urandom);
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_error) begin
          if (exp_ovf.size() == 0) check("error_unexpected", 1, 0);
          else check("error_overflow_flag", o_overflow, exp_ovf.pop_front());
        end else begin
          check("overflow_without_error", o_overflow, 0);
        end
        if (o_value_valid) begin
          if (exp_val.size() == 0) check("value_unexpected", 1, 0);
          else begin
            check("value", o_value, exp_val[0]);
            check("value_digits", o_value_digits, exp_dig[0]);
            if (i_value_ready) begin
              void'(exp_val.pop_front());
              void'(exp_dig.pop_front());
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    string upper = "0123456789ABCDEF";
    string lower = "abcdef";
    string bad   = "GZx.:@/g";
    byte   terms[4] = '{8'h0A, 8'h0D, 8'h20, 8'h2C};

    i_rst_n      = 1'b1;
    i_char_valid = 1'b0;
    i_char       = 8'h00;
    #1;
    do_reset();

    rdy_mode = 0;
    send_str("1A2B\r", 1'b1, 1'b1);

    rdy_mode = 1;
    wait_ready();
    cyc = 0;
    send_str("DEADBEEF,7 ", 1'b0, 1'b1);
    check("emit_bubble_cycles", cyc, 12);

    rdy_mode = 0;
    send_str("123456789\n5\n", 1'b1, 1'b1);
    send_str("12G4 3\n", 1'b1, 1'b1);
    send_str("ff\n", 1'b1, 1'b1);
    send_str("\n\r ,,", 1'b0, 1'b1);

    // Consumer stalls while the source keeps offering a character.
    rdy_mode = 2;
    wait_ready();
    send_str("A5\n", 1'b0, 1'b1);
    i_char_valid = 1'b1;
    i_char       = 8'h43;
    repeat (10) begin
      @(negedge i_clk);
      check("stall_ready_low", o_char_ready, 0);
      check("stall_valid_high", o_value_valid, 1);
      check("stall_value_held", o_value, 64'hA5);
    end
    @(posedge i_clk); #1;
    i_char_valid = 1'b0;
    rdy_mode = 1;
    wait_ready();

    // Reset in the middle of a field drops it.
    send_str("AB", 1'b0, 1'b0);
    do_reset();
    send_str("3\n", 1'b1, 1'b1);

    // Random token stream.
    rdy_mode = 0;
    for (int k = 0; k < 60; k++) begin
      byte q[$];
      int  len = $urandom_range(0, 10);
      for (int j = 0; j < len; j++) begin
        int r = $urandom_range(0, 19);
        if (r < 17)       q.push_back(upper[$urandom_range(0, 15)]);
        else if (r < 19)  q.push_back(lower[$urandom_range(0, 5)]);
        else              q.push_back(bad[$urandom_range(0, 7)]);
      end
      q.push_back(terms[$urandom_range(0, 3)]);
      if ($urandom_range(0, 3) == 0) q.push_back(terms[$urandom_range(0, 3)]);
      send_seq(q, 1'b1, 1'b1);
    end

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #1;
      if (exp_val.size() == 0 && exp_ovf.size() == 0) break;
    end
    repeat (3) @(posedge i_clk);
    #1;
    check("pending_values", exp_val.size(), 0);
    check("pending_errors", exp_ovf.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Streaming decoder that turns an ASCII hexadecimal text field back into a binary value. It is the inverse of the nibble-to-ASCII-hex conversion used for LCD text. It sits between a byte-stream source (UART RX or a command FIFO) and control logic that needs numeric operands such as flash addresses or patterns. Characters are consumed one per cycle under a valid/ready handshake. A complete field is presented as a held value with its own valid/ready handshake.

## Interface
- DIGITS_MAX, 8: maximum hex digits per field. Value width is 4*DIGITS_MAX. Legal range 1..15.
- i_clk  in  1  system clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_char_valid  in  1  source presents a character.
- i_char  in  8  ASCII character.
- o_char_ready  out  1  parser accepts i_char this cycle.
- o_value_valid  out  1  decoded value available.
- o_value  out  4*DIGITS_MAX  decoded value, right-aligned, zero-extended.
- o_value_digits  out  4  number of digits in o_value (1..DIGITS_MAX).
- i_value_ready  in  1  consumer takes the value.
- o_error  out  1  one-cycle pulse on a rejected character or overflow.
- o_overflow  out  1  qualifies o_error: 1 means more than DIGITS_MAX digits.

## Operation
- A character is accepted when i_char_valid && o_char_ready.
- Classes:
  - Hex digit: '0'-'9' (0x30-0x39) or 'A'-'F' (0x41-0x46).
  - Terminator: LF 0x0A, CR 0x0D, space 0x20, comma 0x2C.
  - Anything else is invalid.
- Digit value is i_char-0x30 for 0x30-0x39, and i_char-0x37 for 0x41-0x46.
- State machine, using package enum:
  - ST_IDLE:
    - terminator: ignored, stays in ST_IDLE.
    - digit: acc <= digit, count <= 1, go to ST_ACCUM.
    - invalid: o_error pulse, go to ST_DISCARD.
  - ST_ACCUM:
    - digit with count < DIGITS_MAX: acc <= {acc[4*DIGITS_MAX-5:0], digit}, count++.
    - digit with count == DIGITS_MAX: o_error and o_overflow pulse, go to ST_DISCARD.
    - terminator: latch o_value <= acc and o_value_digits <= count, go to ST_EMIT.
    - invalid: o_error pulse, go to ST_DISCARD.
  - ST_EMIT:
    - o_value_valid = 1 and o_char_ready = 0.
    - On i_value_ready, go to ST_IDLE.
  - ST_DISCARD:
    - Consume characters without effect until a terminator, then go to ST_IDLE.
    - No value is emitted and o_error is not repeated.
- o_value and o_value_digits hold stable while o_value_valid = 1.
- Reset mid-field or mid-emit: the field is lost, all registers clear, no partial value is emitted.

## Timing
- Reset values:
  - o_char_ready 0, o_value_valid 0, o_value 0, o_value_digits 0, o_error 0, o_overflow 0.
  - State ST_IDLE, acc 0, count 0.
- o_char_ready is registered. It rises on the first i_clk edge after i_rst_n deasserts.
- Throughput is one character per cycle in ST_IDLE, ST_ACCUM and ST_DISCARD.
- Latency: terminator accepted at edge N, o_value_valid = 1 after edge N (visible in cycle N+1).
- Handshake, consumer side:
  - o_value_valid is held until the i_value_ready cycle.
  - o_value_valid drops and o_char_ready rises after that same edge, with no idle bubble beyond it.
- Handshake, source side:
  - i_char is ignored while o_char_ready = 0.
  - The source must hold i_char stable until it is accepted.
- o_error and o_overflow are asserted for exactly the cycle following the offending acceptance.
- Consecutive terminators emit nothing extra; an empty field never produces a value.

## Configuration
- ASCII_HEX_LOWERCASE_EN defined: 'a'-'f' (0x61-0x66) are also hex digits, value i_char-0x57.
- ASCII_HEX_LOWERCASE_EN undefined: 0x61-0x66 are invalid characters (o_error, then ST_DISCARD).

## Structure
- Package ascii_hex_parser_pkg contains:
  - t_parse_state enum.
  - Character constants (LF, CR, SPACE, COMMA).
  - Automatic functions is_hex_digit, is_terminator and nibble_of_ascii, with the lowercase branch under the macro.
- No sub-module; classification is pure package functions. The FSM and datapath live in one module.

## Test plan
- Reset release, then "1A2B\r": o_value = 0x00001A2B, o_value_digits = 4, valid held until i_value_ready.
- "DEADBEEF," then "7 " back-to-back, i_value_ready tied 1: values 0xDEADBEEF/8 then 0x00000007/1; o_char_ready low exactly one cycle per emit.
- "123456789\n" (DIGITS_MAX = 8): o_error and o_overflow pulse at the 9th digit; no value; next "5\n" yields 0x5.
- "12G4 3\n": o_error pulse, o_overflow = 0 at 'G'; "G4 " discarded; next value 0x3/1.
- "ff\n": with ASCII_HEX_LOWERCASE_EN gives 0xFF/2; without it gives o_error and no value.
- i_value_ready held 0 for 10 cycles during emit with i_char_valid = 1: no character accepted, o_value stable. Then assert i_rst_n = 0 mid-field "AB": all outputs return to 0 immediately.
